// File: rtl/shake_block_loader.sv
// shake_block_loader: packs a 64-bit MSB-first word stream into 1088-bit rate blocks with bit length and final flag
module shake_block_loader #(
  parameter int RATE = 1088,
  parameter int W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  input  logic [6:0]      in_bits,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [RATE-1:0] blk_data,
  output logic [10:0]     blk_length,
  output logic            blk_final
);
  localparam int NWORDS = RATE / W;
  localparam logic [4:0] LAST = 5'(NWORDS - 1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [4:0] word_cnt;
  logic [6:0] eff;
  logic [W-1:0] mask;
  logic [10:0] len_acc, lane_top;
  always_comb begin
    eff = in_last ? (in_bits > 7'd64 ? 7'd64 : in_bits) : 7'd64;
    mask = ~({W{1'b1}} >> eff);
    len_acc = 11'(W) * {6'b0, word_cnt} + {4'b0, eff};
    lane_top = 11'(RATE - 1) - 11'(W) * {6'b0, word_cnt};
  end
  // blk_data doubles as the assembly buffer; it is frozen while in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      word_cnt <= '0;
      blk_data <= '0;
      blk_valid <= 1'b0;
      blk_length <= '0;
      blk_final <= 1'b0;
      in_ready <= 1'b1;
    end else if (state == FILL) begin
      if (in_valid && in_ready) begin
        blk_data[lane_top -: W] <= in_data & mask;
        if (in_last || word_cnt == LAST) begin
          state <= HOLD;
          in_ready <= 1'b0;
          blk_valid <= 1'b1;
          blk_final <= in_last;
          blk_length <= in_last ? len_acc : 11'(RATE);
        end else word_cnt <= word_cnt + 5'd1;
      end
    end else if (blk_ready) begin
      state <= FILL;
      word_cnt <= '0;
      blk_data <= '0;
      blk_valid <= 1'b0;
      blk_length <= '0;
      blk_final <= 1'b0;
      in_ready <= 1'b1;
    end
  end
endmodule

// File: doc/shake_block_loader.md
Name: shake_block_loader

Overview:
- Upstream neighbour of the SHAKE256 padding stage: turns a 64-bit message word stream into 1088-bit rate blocks plus a valid-bit length, which are exactly the `data_in` / `data_length` operands the pad stage consumes.
- Assembles words MSB-first, tracks the bit count and marks the message's final block so the pad stage applies padding only there.
- Single-buffered, valid/ready on both sides.

Parameters:
- RATE, 1088, rate block width in bits; must equal 17*W.
- W, 64, input word width in bits.
- NWORDS, 17, words per block (RATE/W); derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  64  message word; first message bit at in_data[63].
- in_last  input  1  this word ends the message.
- in_bits  input  7  valid bits in the word when in_last=1, range 0..64, MSB-aligned; ignored when in_last=0 (treated as 64).
- blk_valid  output  1  assembled block available.
- blk_ready  input  1  downstream accepts the block.
- blk_data  output  1088  block; word k at [1087-64k -: 64]; all bits beyond blk_length are 0.
- blk_length  output  11  valid message bits in blk_data, 0..1088.
- blk_final  output  1  block is the message's last; the pad stage pads it.

Behaviour:
- Reset (async, rst=1): state=FILL, word_cnt=0, buffer=0, blk_valid=0, blk_length=0, blk_final=0, in_ready=1 after release. Mid-block or mid-handshake reset discards the partial block and any pending output.
- State FILL: in_ready=1, blk_valid=0.
  - Accept a word on in_valid&in_ready: write the lane at word_cnt.
  - When in_last=1, the word is masked to its top in_bits bits; the low (64-in_bits) bits are forced to 0.
  - length_acc = 64*word_cnt + eff_bits, where eff_bits = in_last ? in_bits : 64. Values of in_bits above 64 are clamped to 64.
  - If in_last=1 → go to HOLD with blk_final=1, blk_length=length_acc.
  - Else if word_cnt=16 → go to HOLD with blk_final=0, blk_length=1088.
  - Else word_cnt++.
- State HOLD: in_ready=0, blk_valid=1; blk_data, blk_length and blk_final stay stable until the handshake.
  - On blk_valid&blk_ready: clear buffer to 0, set word_cnt=0, return to FILL. in_ready rises the next cycle.
- Latency: blk_valid asserts the cycle after the closing word is accepted. Throughput is one word per cycle in FILL plus at least one HOLD cycle per block.
- Lanes never written in a final block read as 0, including an empty message (length 0).
- A message of exactly 17k full words emits k blocks. The last of them has length 1088 and blk_final=1, so the pad stage generates the extra block.
- A last word with in_bits=0 after a full non-final block yields a block with length 0 and blk_final=1. This is legal and hash-equivalent.
- in_bits=0 on a mid-block last word: that lane stays 0 and the length equals 64*word_cnt.
- No combinational path from blk_ready to in_ready; in_ready is a registered function of state.

Test Plan:
- Empty message: one word, in_last=1, in_bits=0, data=FFFF_FFFF_FFFF_FFFF → blk_length=0, blk_final=1, blk_data all zero, blk_valid one cycle after accept.
- 3-word message, last word in_bits=8, data=AB00_0000_0000_0000 → blk_length=136, blk_data[1087:960]=word0,word1, [959:952]=0xAB, rest 0, final=1.
- 34 full words, last flagged on word 34 with in_bits=64 → two blocks, length 1088 each, final=0 then final=1, lane order matches input order.
- Backpressure: hold blk_ready=0 for 10 cycles in HOLD → in_ready=0 throughout, blk_data/length/final stable; release → handshake, in_ready=1 next cycle.
- Reset asserted after 5 words of a block → outputs clear immediately; a new 1-word message with in_bits=5 gives blk_length=5 with no residue from the old words.
- Last word with in_bits=3, data=FFFF_FFFF_FFFF_FFFF → lane holds E000_0000_0000_0000, blk_length=3.
